// File: rtl/adder_pkg.sv
// Shared types and constants for the adder/subtractor family.
package adder_pkg;

  localparam int unsigned WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_sub_cell.sv
// Single-bit full subtractor: d = x - y - bi, bo = borrow out.
module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  // Difference and borrow of one bit position.
  always_comb begin
    d  = x ^ y ^ bi;
    bo = (~x & y) | (~(x ^ y) & bi);
  end

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: a - b - bin, one bit per clock, LSB first.
module serial_sub
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] diff_sh_q;
  logic [WIDTH-1:0] diff_sh_d;
  logic             br_q;
  logic             a_msb_q;
  logic             b_msb_q;

  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;

  logic             cell_d;
  logic             cell_bo;
  logic             last_step;

  // The one and only subtractor cell, fed from the shift-register LSBs.
  full_sub_cell u_cell (
    .x  (a_sh_q[0]),
    .y  (b_sh_q[0]),
    .bi (br_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  assign last_step = (cnt_q == CW'(WIDTH - 1));
  assign diff_sh_d = WIDTH'({cell_d, diff_sh_q} >> 1);

  // State register and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; start only matters in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the upcoming state so they register cleanly.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    if (state_d == RUN)  busy_d = 1'b1;
    if (state_d == DONE) done_d = 1'b1;
  end

  // Datapath: operand load, bit steps, and result capture on the final step.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      diff_sh_q <= '0;
      br_q      <= 1'b0;
      a_msb_q   <= 1'b0;
      b_msb_q   <= 1'b0;
      diff_q    <= '0;
      bout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            br_q    <= bin;
            cnt_q   <= '0;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
          end
        end
        RUN: begin
          a_sh_q    <= a_sh_q >> 1;
          b_sh_q    <= b_sh_q >> 1;
          diff_sh_q <= diff_sh_d;
          br_q      <= cell_bo;
          if (last_step) begin
            // Final bit is the new MSB; results update only here.
            diff_q <= diff_sh_d;
            bout_q <= cell_bo;
            ovf_q  <= (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign diff     = diff_q;
  assign bout     = bout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_sub.sv
// Directed and back-to-back random checks for serial_sub.
module tb_serial_sub;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         overflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_sub #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .bout     (bout),
    .overflow (overflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One operation; optional stray start pulse at cycle restart_at while running.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tbin, input logic [W-1:0] ed, input logic eb,
                        input logic eo, input int restart_at);
    int lat = 0;
    int busy_n = 0;
    int dones = 0;
    int both = 0;
    logic [W-1:0] od = '0;
    logic ob = 1'b0;
    logic oo = 1'b0;
    @(negedge clk);
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = ~ta; b = ~tb_v; bin = ~tbin;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == restart_at) begin
        start = 1'b1; a = 32'h1234_5678; b = 32'h0000_0042; bin = 1'b1;
      end else if (k == restart_at + 1) begin
        start = 1'b0;
      end
      if (busy) busy_n++;
      if (busy && done) both++;
      if (done) begin
        dones++;
        if (lat == 0) begin
          lat = k; od = diff; ob = bout; oo = overflow;
        end
      end
    end
    check({tag, "/latency"}, 64'(lat), 64'd33);
    check({tag, "/busy_cycles"}, 64'(busy_n), 64'd32);
    check({tag, "/busy_and_done"}, 64'(both), 64'd0);
    check({tag, "/done_pulses"}, 64'(dones), 64'd1);
    check({tag, "/diff"}, 64'(od), 64'(ed));
    check({tag, "/bout"}, 64'(ob), 64'(eb));
    check({tag, "/overflow"}, 64'(oo), 64'(eo));
    check({tag, "/diff_hold"}, 64'(diff), 64'(ed));
  endtask

  // Launch an operation and abort it with reset at cycle 10.
  task automatic run_abort();
    int dones = 0;
    @(negedge clk);
    a = 32'h0000_0100; b = 32'h0000_0001; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 10) rst = 1'b1;
      if (k == 11) begin
        rst = 1'b0;
        check("abort/busy", 64'(busy), 64'd0);
        check("abort/done", 64'(done), 64'd0);
        check("abort/diff", 64'(diff), 64'd0);
        check("abort/bout", 64'(bout), 64'd0);
        check("abort/overflow", 64'(overflow), 64'd0);
      end
      if (done) dones++;
    end
    check("abort/done_pulses", 64'(dones), 64'd0);
  endtask

  // Back-to-back random operations, new start presented during each DONE cycle.
  task automatic run_random(input int n);
    logic [W-1:0] ra, rb, ed;
    logic         rbin, eb, eo;
    logic [W:0]   full;
    int           cyc;
    bit           timed_out = 1'b0;
    @(negedge clk);
    ra = $urandom; rb = $urandom; rbin = 1'($urandom_range(0, 1));
    a = ra; b = rb; bin = rbin; start = 1'b1;
    for (int i = 0; i < n && !timed_out; i++) begin
      full = {1'b0, ra} - {1'b0, rb} - (W + 1)'(rbin);
      ed   = full[W-1:0];
      eb   = full[W];
      eo   = (ra[W-1] != rb[W-1]) && (ed[W-1] != ra[W-1]);
      cyc  = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!done && cyc < 40);
      if (!done) begin
        check("rand/timeout", 64'(cyc), 64'd34);
        timed_out = 1'b1;
      end else begin
        check("rand/spacing", 64'(cyc), (i == 0) ? 64'd33 : 64'd34);
        check("rand/diff", 64'(diff), 64'(ed));
        check("rand/bout", 64'(bout), 64'(eb));
        check("rand/overflow", 64'(overflow), 64'(eo));
        ra = $urandom; rb = $urandom; rbin = 1'($urandom_range(0, 1));
        a = ra; b = rb; bin = rbin;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset/busy", 64'(busy), 64'd0);
    check("reset/done", 64'(done), 64'd0);
    check("reset/diff", 64'(diff), 64'd0);
    check("reset/bout", 64'(bout), 64'd0);
    check("reset/overflow", 64'(overflow), 64'd0);
    rst = 1'b0;

    run_op("5-3",      32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 0);
    run_op("0-1",      32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
    run_op("min-1",    32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 0);
    run_op("max-m1",   32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 0);
    run_op("10-f-bin", 32'h0000_0010, 32'h0000_000F, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 0);
    run_op("0-0-bin",  32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
    run_op("restart",  32'h0000_0064, 32'h0000_0019, 1'b0, 32'h0000_004B, 1'b0, 1'b0, 5);
    run_op("pre-abort",32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
    run_abort();
    run_op("fresh",    32'hDEAD_BEEF, 32'h0000_BEEF, 1'b0, 32'hDEAD_0000, 1'b0, 1'b0, 0);

    run_random(1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
